// File: rtl/wb_arbiter.sv
// Writeback arbiter: three units (LSU, IXU1, IXU2) share register-file write slots.
// Same-rd collisions are resolved by a rotating (or fixed) priority; losers are held off.
module wb_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  input  logic        ixu1_wb_valid,
  input  logic [4:0]  ixu1_wb_rd,
  input  logic [31:0] ixu1_wb_data,
  output logic        ixu1_wb_ready,
  input  logic        ixu2_wb_valid,
  input  logic [4:0]  ixu2_wb_rd,
  input  logic [31:0] ixu2_wb_data,
  output logic        ixu2_wb_ready,

  output logic        lsu_wr_en,
  output logic [4:0]  lsu_rd,
  output logic [31:0] lsu_wr_data,
  output logic        ixu1_wr_en,
  output logic [4:0]  ixu1_rd,
  output logic [31:0] ixu1_wr_data,
  output logic        ixu2_wr_en,
  output logic [4:0]  ixu2_rd,
  output logic [31:0] ixu2_wr_data,

  input  logic        cnt_clr,
  output logic [15:0] conflict_cnt
);

  localparam int N = 3;

  logic [N-1:0] valid;
  logic [4:0]   req_rd   [N];
  logic [31:0]  req_data [N];

  assign valid       = {ixu2_wb_valid, ixu1_wb_valid, lsu_wb_valid};
  assign req_rd[0]   = lsu_wb_rd;
  assign req_rd[1]   = ixu1_wb_rd;
  assign req_rd[2]   = ixu2_wb_rd;
  assign req_data[0] = lsu_wb_data;
  assign req_data[1] = ixu1_wb_data;
  assign req_data[2] = ixu2_wb_data;

  logic [1:0]   ptr, ptr_next;
  logic [1:0]   order [N];   // order[p] is the unit holding priority slot p
  logic [N-1:0] denied;
  logic [N-1:0] ready;
  logic [N-1:0] fire;
  logic [N-1:0] lost;
  logic         any_lost;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    order[0] = ptr;
    order[1] = (ptr == 2'd2) ? 2'd0 : 2'(ptr + 2'd1);
    order[2] = (ptr == 2'd0) ? 2'd2 : 2'(ptr - 2'd1);
  end

  always_comb begin
    denied = '0;
    for (int p = 1; p < N; p++) begin
      for (int q = 0; q < p; q++) begin
        if (valid[order[q]] && (req_rd[order[q]] == req_rd[order[p]]))
          denied[order[p]] = 1'b1;
      end
    end
  end

  assign ready    = rst_n ? ~denied : '0;
  assign fire     = valid & ready;
  assign lost     = valid & denied;
  assign any_lost = |lost;

  // Scan lowest priority first so the highest-priority loser wins the pointer.
  always_comb begin
    ptr_next = ptr;
    if (RR_EN) begin
      for (int p = N - 1; p >= 0; p--) begin
        if (lost[order[p]])
          ptr_next = order[p];
      end
    end else begin
      ptr_next = 2'd0;
    end
  end

  logic [N-1:0] wr_en_q;
  logic [4:0]   rd_q   [N];
  logic [31:0]  data_q [N];
  logic [15:0]  cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 2'd0;
      wr_en_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      ptr     <= ptr_next;
      wr_en_q <= fire;
      for (int i = 0; i < N; i++) begin
        if (fire[i]) begin
          rd_q[i]   <= req_rd[i];
          data_q[i] <= req_data[i];
        end
      end
      if (cnt_clr)
        cnt_q <= '0;
      else if (any_lost && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign lsu_wb_ready  = ready[0];
  assign ixu1_wb_ready = ready[1];
  assign ixu2_wb_ready = ready[2];

  assign lsu_wr_en     = wr_en_q[0];
  assign lsu_rd        = rd_q[0];
  assign lsu_wr_data   = data_q[0];
  assign ixu1_wr_en    = wr_en_q[1];
  assign ixu1_rd       = rd_q[1];
  assign ixu1_wr_data  = data_q[1];
  assign ixu2_wr_en    = wr_en_q[2];
  assign ixu2_rd       = rd_q[2];
  assign ixu2_wr_data  = data_q[2];

  assign conflict_cnt  = cnt_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin priority rotation, 0 = fixed priority LSU > IXU1 > IXU2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 {lsu,ixu1,ixu2}_wb_valid  input  1  writeback request from the unit.
REQ-005 {lsu,ixu1,ixu2}_wb_rd  input  5  destination register.
REQ-006 {lsu,ixu1,ixu2}_wb_data  input  32  writeback data.
REQ-007 {lsu,ixu1,ixu2}_wb_ready  output  1  request accepted this cycle (combinational).
REQ-008 {lsu,ixu1,ixu2}_wr_en  output  1  registered write enable to the register file port of the same unit.
REQ-009 {lsu,ixu1,ixu2}_rd  output  5  registered destination to the register file port.
REQ-010 {lsu,ixu1,ixu2}_wr_data  output  32  registered write data to the register file port.
REQ-011 cnt_clr  input  1  synchronous clear of conflict_cnt.
REQ-012 conflict_cnt  output  16  saturating count of cycles with at least one denied request.

Function
REQ-013 Unit indices SHALL be LSU=0, IXU1=1, IXU2=2; the 2-bit pointer ptr selects the top-priority unit, with order ptr, ptr+1, ptr+2 mod 3.
REQ-014 Unit i SHALL be denied when a higher-priority unit j has wb_valid=1 and wb_rd_j == wb_rd_i; r0 is treated like any other register.
REQ-015 wb_ready_i SHALL be 1 exactly when rst_n=1 and unit i is not denied, independent of its own wb_valid.
REQ-016 Unit i fires when wb_valid_i & wb_ready_i; a requester SHALL hold valid, rd and data stable until it fires.
REQ-017 Fire to write latency SHALL be 1 cycle: on the next posedge, wr_en_i <= fire_i; rd_i and wr_data_i load the request only when fire_i=1 and otherwise hold.
REQ-018 Lanes SHALL NOT be remapped: a request from unit i always drives register file port i.
REQ-019 Requests with distinct rd SHALL all fire in the same cycle with no added latency.
REQ-020 A 3-way same-rd collision SHALL fire the top-priority unit only; the other two are denied.
REQ-021 With RR_EN=1, in any cycle with at least one valid denied request, ptr SHALL become the highest-priority denied unit; otherwise ptr holds.
REQ-022 With RR_EN=1, a held denied request SHALL fire within 2 cycles of its first denial (bounded starvation).
REQ-023 With RR_EN=0, ptr SHALL remain 0 permanently.
REQ-024 conflict_cnt SHALL increment by 1 per cycle with at least one valid denied request, saturate at 16'hFFFF, and clear to 0 on cnt_clr; cnt_clr wins over a simultaneous increment.

Reset
REQ-025 While rst_n=0 (asynchronously on assertion): all wr_en, rd, wr_data, conflict_cnt = 0; ptr = 0; all wb_ready = 0.
REQ-026 Requests pending when reset asserts SHALL be dropped with no write issued; requesters re-present them after release.
REQ-027 On the first posedge after rst_n rises, arbitration SHALL resume normally from ptr=0.

Verification
REQ-028 No conflict: LSU rd3 / 0xA, IXU1 rd4 / 0xB, IXU2 rd5 / 0xC valid together -> all three ready; next cycle all wr_en=1 with those rd and data; conflict_cnt stays 0.
REQ-029 2-way conflict at ptr=0: LSU rd7 / 0x11 and IXU1 rd7 / 0x22 -> LSU fires; IXU1 ready=0; ptr -> 1; cnt=1; next cycle IXU1 fires; writes appear on the lsu and ixu1 ports in consecutive cycles.
REQ-030 3-way rd9, held from ptr=0 -> fire order LSU, IXU1, IXU2 on three consecutive cycles; conflict_cnt=2.
REQ-031 Starvation: LSU issues a new rd5 request every cycle while IXU2 holds rd5 -> IXU2 fires within 2 cycles; with RR_EN=0, IXU2 never fires.
REQ-032 Reset mid-operation: rst_n low asynchronously while lsu_wr_en=1 and ptr=2 -> outputs, ptr and count go to 0 before the next edge; no write for the pending request.
REQ-033 Counter: force 65536+ conflict cycles -> conflict_cnt holds 0xFFFF; cnt_clr together with a conflict -> 0.
